// File: rtl/cpu_types_pkg.sv
// Shared decode/issue types: task_t bundle, issue-queue entry,
// queue depth and register-width constants, memory-op classifier.
package cpu_types;

    localparam int IQ_DEPTH = 8;
    localparam int REG_AW   = 5;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_ALU,
        OP_ALUI,
        OP_LOAD,
        OP_STORE,
        OP_BRANCH,
        OP_JUMP
    } opcode_e;

    typedef struct packed {
        opcode_e           opcode;
        logic [REG_AW-1:0] rd_addr;
        logic              rd_used;
        logic [REG_AW-1:0] rs1_addr;
        logic              rs1_used;
        logic [REG_AW-1:0] rs2_addr;
        logic              rs2_used;
        logic [31:0]       imm;
    } task_t;

    typedef struct packed {
        logic  valid;
        task_t data;
    } iq_entry_t;

    function automatic logic is_mem_op(input task_t t);
        return (t.opcode == OP_LOAD) || (t.opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Busy-bit scoreboard: two set ports (issue), one clear port (writeback).
// Ports: clk, rst, set0/set1 en+addr, clr en+addr, busy vector out.
module issue_scoreboard
    import cpu_types::*;
#(
    parameter int NREG = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set0_en,
    input  logic [REG_AW-1:0] set0_addr,
    input  logic              set1_en,
    input  logic [REG_AW-1:0] set1_addr,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_addr,
    output logic [NREG-1:0]   busy
);

    // Bit 0 is only ever written by reset, so x0 stays clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if ((set0_en && set0_addr == REG_AW'(r)) ||
                    (set1_en && set1_addr == REG_AW'(r)))
                    busy[r] <= 1'b1;
                else if (clr_en && clr_addr == REG_AW'(r))
                    busy[r] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Collapsing age-ordered issue queue with ALU and in-order MEM ports.
// Ports: CLK/RST, two dispatch lanes, FLUSH, writeback, ALU/MEM issue.
module issue_scheduler
    import cpu_types::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int NREG  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  task_t             TASK_0,
    input  task_t             TASK_1,
    input  logic              VALID_0,
    input  logic              VALID_1,
    output logic              DISP_READY,
    input  logic              FLUSH,
    input  logic              WB_EN,
    input  logic [REG_AW-1:0] WB_ADDR,
    output logic              ALU_VALID,
    output task_t             ALU_TASK,
    input  logic              ALU_READY,
    output logic              MEM_VALID,
    output task_t             MEM_TASK,
    input  logic              MEM_READY
);

    iq_entry_t        q     [DEPTH];
    iq_entry_t        q_nxt [DEPTH];
    logic [NREG-1:0]  busy;
    logic [DEPTH-1:0] elig;
    logic [DEPTH-1:0] blk;
    logic [DEPTH-1:0] alu_hit;
    logic [DEPTH-1:0] mem_hit;
    logic [DEPTH-1:0] keep;
    logic             alu_fire;
    logic             mem_fire;
    logic             disp;
    int               pos   [DEPTH];
    int               kept;

    // Younger y reads a register older o will write.
    function automatic logic raw_hit(input task_t y, input task_t o);
        return o.rd_used && o.rd_addr != '0 &&
               ((y.rs1_used && y.rs1_addr == o.rd_addr) ||
                (y.rs2_used && y.rs2_addr == o.rd_addr));
    endfunction

    // Younger y writes a register older o still reads or writes.
    function automatic logic wr_hit(input task_t y, input task_t o);
        return y.rd_used && y.rd_addr != '0 &&
               ((o.rs1_used && o.rs1_addr == y.rd_addr) ||
                (o.rs2_used && o.rs2_addr == y.rd_addr) ||
                (o.rd_used  && o.rd_addr  == y.rd_addr));
    endfunction

    function automatic logic sb_hit(input task_t t,
                                    input logic [NREG-1:0] b);
        return (t.rs1_used && b[t.rs1_addr]) ||
               (t.rs2_used && b[t.rs2_addr]) ||
               (t.rd_used  && b[t.rd_addr]);
    endfunction

    // Entries are contiguous from slot 0, so slot DEPTH-2 empty
    // means at least two free slots.
    assign DISP_READY = !q[DEPTH-2].valid;

    always_comb begin
        blk  = '0;
        elig = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j < i && q[j].valid &&
                    (raw_hit(q[i].data, q[j].data) ||
                     wr_hit(q[i].data, q[j].data)))
                    blk[i] = 1'b1;
            end
            elig[i] = q[i].valid && !blk[i] &&
                      !sb_hit(q[i].data, busy);
        end
    end

    // MEM only ever looks at the oldest queued memory op, which
    // keeps loads and stores in program order.
    always_comb begin
        logic mem_seen;
        mem_seen  = 1'b0;
        ALU_VALID = 1'b0;
        ALU_TASK  = '0;
        MEM_VALID = 1'b0;
        MEM_TASK  = '0;
        alu_hit   = '0;
        mem_hit   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ALU_VALID && elig[i] &&
                !is_mem_op(q[i].data)) begin
                ALU_VALID  = 1'b1;
                ALU_TASK   = q[i].data;
                alu_hit[i] = 1'b1;
            end
            if (!mem_seen && q[i].valid &&
                is_mem_op(q[i].data)) begin
                mem_seen = 1'b1;
                if (elig[i]) begin
                    MEM_VALID  = 1'b1;
                    MEM_TASK   = q[i].data;
                    mem_hit[i] = 1'b1;
                end
            end
        end
    end

    assign alu_fire = ALU_VALID && ALU_READY;
    assign mem_fire = MEM_VALID && MEM_READY;
    assign disp     = DISP_READY && VALID_0 && !FLUSH;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            keep[i] = q[i].valid &&
                      !(alu_hit[i] && alu_fire) &&
                      !(mem_hit[i] && mem_fire);
    end

    // Survivors slide down to their rank; new tasks append after.
    always_comb begin
        kept = 0;
        for (int i = 0; i < DEPTH; i++) begin
            pos[i] = kept;
            if (keep[i])
                kept = kept + 1;
        end
        for (int k = 0; k < DEPTH; k++) begin
            q_nxt[k] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (keep[i] && pos[i] == k)
                    q_nxt[k] = q[i];
            end
            if (disp && k == kept)
                q_nxt[k] = '{valid: 1'b1, data: TASK_0};
            if (disp && VALID_1 && k == kept + 1)
                q_nxt[k] = '{valid: 1'b1, data: TASK_1};
        end
    end

    always_ff @(posedge CLK) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (RST || FLUSH)
                q[k] <= '0;
            else
                q[k] <= q_nxt[k];
        end
    end

    issue_scoreboard #(
        .NREG(NREG)
    ) u_sb (
        .clk      (CLK),
        .rst      (RST),
        .set0_en  (alu_fire && ALU_TASK.rd_used),
        .set0_addr(ALU_TASK.rd_addr),
        .set1_en  (mem_fire && MEM_TASK.rd_used),
        .set1_addr(MEM_TASK.rd_addr),
        .clr_en   (WB_EN),
        .clr_addr (WB_ADDR),
        .busy     (busy)
    );

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: ordering, hazards, full/flush,
// memory ordering, scoreboard set/clear priority, reset.
module tb_issue_scheduler;
    import cpu_types::*;

    logic        CLK = 1'b0;
    logic        RST;
    task_t       TASK_0, TASK_1;
    logic        VALID_0, VALID_1;
    logic        DISP_READY;
    logic        FLUSH;
    logic        WB_EN;
    logic [4:0]  WB_ADDR;
    logic        ALU_VALID, ALU_READY;
    task_t       ALU_TASK;
    logic        MEM_VALID, MEM_READY;
    task_t       MEM_TASK;

    int n_checks = 0;
    int n_errs   = 0;

    issue_scheduler dut (
        .CLK(CLK), .RST(RST),
        .TASK_0(TASK_0), .TASK_1(TASK_1),
        .VALID_0(VALID_0), .VALID_1(VALID_1),
        .DISP_READY(DISP_READY), .FLUSH(FLUSH),
        .WB_EN(WB_EN), .WB_ADDR(WB_ADDR),
        .ALU_VALID(ALU_VALID), .ALU_TASK(ALU_TASK),
        .ALU_READY(ALU_READY),
        .MEM_VALID(MEM_VALID), .MEM_TASK(MEM_TASK),
        .MEM_READY(MEM_READY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; pulse inputs drop right after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
        VALID_0 = 1'b0;
        VALID_1 = 1'b0;
        FLUSH   = 1'b0;
        WB_EN   = 1'b0;
    endtask

    function automatic task_t mk(input opcode_e op,
                                 input logic [4:0] rd, input logic rdu,
                                 input logic [4:0] r1, input logic r1u,
                                 input logic [4:0] r2, input logic r2u,
                                 input logic [31:0] imm);
        task_t t;
        t.opcode   = op;
        t.rd_addr  = rd;
        t.rd_used  = rdu;
        t.rs1_addr = r1;
        t.rs1_used = r1u;
        t.rs2_addr = r2;
        t.rs2_used = r2u;
        t.imm      = imm;
        return t;
    endfunction

    function automatic task_t addi(input logic [4:0] rd,
                                   input logic [4:0] rs,
                                   input logic [31:0] imm);
        return mk(OP_ALUI, rd, 1'b1, rs, 1'b1, 5'd0, 1'b0, imm);
    endfunction

    function automatic task_t add(input logic [4:0] rd,
                                  input logic [4:0] a,
                                  input logic [4:0] b);
        return mk(OP_ALU, rd, 1'b1, a, 1'b1, b, 1'b1, 32'd0);
    endfunction

    task automatic disp1(input task_t a);
        TASK_0 = a; VALID_0 = 1'b1;
        step();
    endtask

    task automatic disp2(input task_t a, input task_t b);
        TASK_0 = a; VALID_0 = 1'b1;
        TASK_1 = b; VALID_1 = 1'b1;
        step();
    endtask

    task automatic wb(input logic [4:0] r);
        WB_EN = 1'b1; WB_ADDR = r;
        step();
    endtask

    task_t lw8, sw10, t;

    initial begin
        RST = 1'b1; TASK_0 = '0; TASK_1 = '0;
        VALID_0 = 0; VALID_1 = 0; FLUSH = 0;
        WB_EN = 0; WB_ADDR = '0;
        ALU_READY = 0; MEM_READY = 0;
        step(); step();
        RST = 1'b0;
        check("rst_disp_ready", DISP_READY, 1);
        check("rst_alu_valid", ALU_VALID, 0);
        check("rst_mem_valid", MEM_VALID, 0);
        check("rst_busy", dut.busy, 0);

        // independent pair, issued oldest first
        ALU_READY = 1'b1;
        disp2(addi(5'd1, 5'd0, 5), addi(5'd2, 5'd0, 7));
        check("pair_v1", ALU_VALID, 1);
        check("pair_t1", ALU_TASK, addi(5'd1, 5'd0, 5));
        step();
        check("pair_t2", ALU_TASK, addi(5'd2, 5'd0, 7));
        check("pair_busy1", dut.busy, 32'h2);
        step();
        check("pair_busy12", dut.busy, 32'h6);
        check("pair_idle", ALU_VALID, 0);

        // RAW stall until writeback of x3
        disp2(addi(5'd3, 5'd0, 1), add(5'd4, 5'd3, 5'd3));
        check("raw_first", ALU_TASK, addi(5'd3, 5'd0, 1));
        step();
        check("raw_hold0", ALU_VALID, 0);
        step();
        check("raw_hold1", ALU_VALID, 0);
        wb(5'd3);
        check("raw_go_v", ALU_VALID, 1);
        check("raw_go_t", ALU_TASK, add(5'd4, 5'd3, 5'd3));
        step();
        check("raw_busy", dut.busy, 32'h16);
        check("raw_idle", ALU_VALID, 0);

        // WAR: younger writers of x6/x7 wait for the reader
        disp1(addi(5'd6, 5'd0, 9));
        step();
        check("war_busy6", dut.busy, 32'h56);
        disp2(add(5'd5, 5'd6, 5'd7), addi(5'd6, 5'd0, 2));
        check("war_hold0", ALU_VALID, 0);
        disp1(addi(5'd7, 5'd0, 2));
        check("war_hold1", ALU_VALID, 0);
        wb(5'd6);
        check("war_add", ALU_TASK, add(5'd5, 5'd6, 5'd7));
        step();
        check("war_x6", ALU_TASK, addi(5'd6, 5'd0, 2));
        step();
        check("war_x7", ALU_TASK, addi(5'd7, 5'd0, 2));
        step();
        check("war_busy", dut.busy, 32'hF6);
        check("war_idle", ALU_VALID, 0);

        // fill with blocked tasks, then flush
        for (int p = 0; p < 3; p++)
            disp2(add(5'(20 + 2 * p), 5'd1, 5'd2),
                  add(5'(21 + 2 * p), 5'd1, 5'd2));
        check("full_rdy6", DISP_READY, 1);
        disp1(add(5'd26, 5'd1, 5'd2));
        check("full_rdy7", DISP_READY, 0);
        check("full_blocked", ALU_VALID, 0);
        disp1(addi(5'd27, 5'd0, 1));
        check("full_ignored", ALU_VALID, 0);
        check("full_rdy_still", DISP_READY, 0);
        FLUSH = 1'b1;
        step();
        check("flush_rdy", DISP_READY, 1);
        check("flush_alu", ALU_VALID, 0);
        check("flush_busy", dut.busy, 32'hF6);
        disp1(add(5'd29, 5'd20, 5'd20));
        check("flush_empty", ALU_TASK, add(5'd29, 5'd20, 5'd20));
        step();
        check("flush_busy29", dut.busy, 32'h200000F6);

        // memory ordering with ALU bypass
        MEM_READY = 1'b1;
        disp1(addi(5'd9, 5'd0, 1));
        step();
        lw8  = mk(OP_LOAD, 5'd8, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 0);
        sw10 = mk(OP_STORE, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 1'b1, 4);
        disp2(lw8, sw10);
        check("mem_lw_blk", MEM_VALID, 0);
        t = addi(5'd11, 5'd0, 3);
        disp1(t);
        check("mem_alu_pass", ALU_TASK, t);
        check("mem_sw_wait", MEM_VALID, 0);
        step();
        wb(5'd9);
        check("mem_lw", MEM_TASK, lw8);
        step();
        check("mem_sw", MEM_TASK, sw10);
        step();
        check("mem_idle", MEM_VALID, 0);
        check("mem_busy", dut.busy, 32'h200009F6);

        // issue set beats same-cycle writeback clear
        disp1(addi(5'd12, 5'd0, 1));
        check("sc_valid", ALU_VALID, 1);
        wb(5'd12);
        check("sc_set_wins", dut.busy[12], 1);
        wb(5'd12);
        check("sc_clear", dut.busy[12], 0);

        // reset with a queued task
        disp1(add(5'd13, 5'd1, 5'd2));
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("mrst_busy", dut.busy, 0);
        check("mrst_alu", ALU_VALID, 0);
        check("mrst_rdy", DISP_READY, 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
